// File: rtl/seq_shift_unit_if.sv
// Handshake and data bundle for the iterative shifter: the requester drives operands and START,
// the shifter returns RESULT with BUSY/DONE/ERROR status.
interface seq_shift_unit_if #(
  parameter int unsigned Width = 8
);
  logic             start;
  logic             dir;
  logic [Width-1:0] data1;
  logic [7:0]       data2;
  logic [Width-1:0] result;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, dir, data1, data2,
    input  result, busy, done, error
  );

  modport slave (
    input  start, dir, data1, data2,
    output result, busy, done, error
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: moves the operand one bit per clock, left or right,
// in logical, arithmetic or rotate mode, under a start/busy/done handshake.
module seq_shift_unit #(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  seq_shift_unit_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;
  typedef enum logic [1:0] {ModeLog = 2'b00, ModeArith = 2'b01, ModeRot = 2'b10,
                            ModeRsvd = 2'b11} mode_e;

  localparam logic [CntW-1:0] MaxCnt  = CntW'(Width);
  localparam logic [CntW-1:0] RotMask = CntW'(Width - 1);

  state_e            state_q;
  mode_e             mode_q;
  logic              dir_q;
  logic              error_q;
  logic [Width-1:0]  shreg_q;
  logic [CntW-1:0]   cnt_q;

  mode_e             mode_in;
  logic [CntW-1:0]   amt_in;
  logic [CntW-1:0]   eff_cnt;
  logic              fill_l;
  logic              fill_r;
  logic [Width-1:0]  step_val;
  logic              accept;
  logic              unused_data2;

  assign mode_in      = mode_e'(bus_io.data2[7:6]);
  assign amt_in       = bus_io.data2[CntW-1:0];
  assign unused_data2 = ^bus_io.data2[5:4];
  assign accept       = bus_io.start && (state_q != StShift);

  // Shifts saturate at Width steps (full zero/sign fill); rotates wrap modulo Width.
  always_comb begin
    eff_cnt = '0;
    unique case (mode_in)
      ModeLog, ModeArith: eff_cnt = (amt_in > MaxCnt) ? MaxCnt : amt_in;
      ModeRot:            eff_cnt = amt_in & RotMask;
      default:            eff_cnt = '0;
    endcase
  end

  always_comb begin
    fill_l = (mode_q == ModeRot) ? shreg_q[Width-1] : 1'b0;
    fill_r = 1'b0;
    unique case (mode_q)
      ModeRot:   fill_r = shreg_q[0];
      ModeArith: fill_r = shreg_q[Width-1];
      default:   fill_r = 1'b0;
    endcase
    step_val = dir_q ? {fill_r, shreg_q[Width-1:1]} : {shreg_q[Width-2:0], fill_l};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= ModeLog;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StShift: begin
          shreg_q <= step_val;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StFin;
        end
        StIdle, StFin: begin
          if (accept) begin
            shreg_q <= bus_io.data1;
            mode_q  <= mode_in;
            dir_q   <= bus_io.dir;
            cnt_q   <= eff_cnt;
            error_q <= (mode_in == ModeRsvd);
            state_q <= (eff_cnt != '0) ? StShift : StFin;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.result = shreg_q;
  assign bus_io.busy   = (state_q == StShift);
  assign bus_io.done   = (state_q == StFin);
  assign bus_io.error  = error_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vector table, handshake/reset sequences
// and randomized operations against an arithmetic reference model.
module tb_seq_shift_unit;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;

  seq_shift_unit_if #(.Width(8)) bus ();

  seq_shift_unit #(.Width(8), .CntW(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] d1;
    logic [7:0] d2;
    logic       dir;
    logic [7:0] exp_res;
    int         exp_n;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: closed-form shift/rotate by the effective count.
  task automatic model(input logic [7:0] d1, input logic [7:0] d2, input logic dir,
                       output logic [7:0] r, output int n, output logic err);
    int a, x, sx, v;
    a  = int'(d2[3:0]);
    x  = int'(d1);
    sx = {{24{d1[7]}}, d1};
    err = 1'b0;
    v   = x;
    case (d2[7:6])
      2'b11: begin n = 0; err = 1'b1; v = x; end
      2'b10: begin
        n = a % 8;
        v = dir ? ((x >> n) | (x << (8 - n))) : ((x << n) | (x >> (8 - n)));
      end
      default: begin
        n = (a > 8) ? 8 : a;
        if (!dir)             v = x << n;
        else if (d2[7:6] == 2'b01) v = sx >>> n;
        else                  v = x >> n;
      end
    endcase
    r = 8'(v & 255);
  endtask

  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      @(negedge clk_i);
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic drive(input logic [7:0] d1, input logic [7:0] d2, input logic dir);
    bus.data1 = d1;
    bus.data2 = d2;
    bus.dir   = dir;
    bus.start = 1'b1;
  endtask

  task automatic run_op(input logic [7:0] d1, input logic [7:0] d2, input logic dir,
                        output logic [7:0] res, output int nbusy, output logic err);
    @(negedge clk_i);
    drive(d1, d2, dir);
    @(negedge clk_i);
    bus.start = 1'b0;
    wait_done(nbusy);
    res = bus.result;
    err = bus.error;
  endtask

  vec_t       vecs[10];
  logic [7:0] res, mres, hold;
  logic       err, merr;
  int         nb, mn;

  initial begin
    checks = 0;
    errors = 0;
    rst_ni    = 1'b0;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;

    vecs[0] = '{8'hB4, 8'h03, 1'b1, 8'h16, 3, 1'b0};
    vecs[1] = '{8'hB4, 8'h42, 1'b1, 8'hED, 2, 1'b0};
    vecs[2] = '{8'h80, 8'h49, 1'b1, 8'hFF, 8, 1'b0};
    vecs[3] = '{8'h81, 8'h81, 1'b0, 8'h03, 1, 1'b0};
    vecs[4] = '{8'h81, 8'h81, 1'b1, 8'hC0, 1, 1'b0};
    vecs[5] = '{8'hFF, 8'h0C, 1'b0, 8'h00, 8, 1'b0};
    vecs[6] = '{8'h5A, 8'h00, 1'b0, 8'h5A, 0, 1'b0};
    vecs[7] = '{8'h5A, 8'h88, 1'b0, 8'h5A, 0, 1'b0};
    vecs[8] = '{8'h5A, 8'hC3, 1'b1, 8'h5A, 0, 1'b1};
    vecs[9] = '{8'h0F, 8'h01, 1'b0, 8'h1E, 1, 1'b0};

    repeat (2) @(negedge clk_i);
    chk("rst_result", 32'(bus.result), 32'h00);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_error",  32'(bus.error),  32'd0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].d1, vecs[i].d2, vecs[i].dir, res, nb, err);
      chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_busy",   i), 32'(nb),  32'(vecs[i].exp_n));
      chk($sformatf("vec%0d_error",  i), 32'(err), 32'(vecs[i].exp_err));
      @(negedge clk_i);
      chk($sformatf("vec%0d_done_pulse", i), 32'(bus.done),   32'd0);
      chk($sformatf("vec%0d_hold",       i), 32'(bus.result), 32'(vecs[i].exp_res));
    end

    // START while busy must be ignored.
    @(negedge clk_i);
    drive(8'hB4, 8'h03, 1'b1);
    @(negedge clk_i);
    bus.start = 1'b0;
    chk("ign_busy", 32'(bus.busy), 32'd1);
    drive(8'hFF, 8'h01, 1'b0);
    @(negedge clk_i);
    bus.start = 1'b0;
    wait_done(nb);
    chk("ign_busy_cycles", 32'(nb + 1), 32'd3);
    chk("ign_result", 32'(bus.result), 32'h16);

    // Back-to-back START in the FIN cycle.
    @(negedge clk_i);
    drive(8'h81, 8'h81, 1'b0);
    @(negedge clk_i);
    bus.start = 1'b0;
    wait_done(nb);
    chk("b2b_first", 32'(bus.result), 32'h03);
    drive(8'hB4, 8'h42, 1'b1);
    @(negedge clk_i);
    bus.start = 1'b0;
    chk("b2b_no_gap", 32'(bus.busy), 32'd1);
    wait_done(nb);
    chk("b2b_busy", 32'(nb), 32'd2);
    chk("b2b_second", 32'(bus.result), 32'hED);

    // Asynchronous reset mid-shift.
    @(negedge clk_i);
    drive(8'h80, 8'h49, 1'b1);
    @(negedge clk_i);
    bus.start = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_result", 32'(bus.result), 32'h00);
    chk("arst_busy",   32'(bus.busy),   32'd0);
    chk("arst_done",   32'(bus.done),   32'd0);
    chk("arst_error",  32'(bus.error),  32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op(8'h0F, 8'h01, 1'b0, res, nb, err);
    chk("post_rst_result", 32'(res), 32'h1E);
    chk("post_rst_busy",   32'(nb),  32'd1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d1, d2;
      logic       dir;
      d1  = 8'($urandom);
      d2  = 8'($urandom);
      dir = 1'($urandom);
      model(d1, d2, dir, mres, mn, merr);
      run_op(d1, d2, dir, res, nb, err);
      chk($sformatf("rnd%0d_result d1=%0h d2=%0h dir=%0b", k, d1, d2, dir), 32'(res),
          32'(mres));
      chk($sformatf("rnd%0d_busy", k),  32'(nb),  32'(mn));
      chk($sformatf("rnd%0d_error", k), 32'(err), 32'(merr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Multi-cycle iterative shifter/rotator for the ALU. It moves the operand one bit position per clock in either direction, under a start/busy/done handshake. It complements the combinational shift units. It adds the opposite rotate direction (rotate-left) and an explicit left/right selector, and uses the same DATA2 mode encoding. It trades latency for area: one 8-bit register, one 4-bit counter and a small FSM.

Parameters:
WIDTH, 8, operand/result width; the design and tests assume 8
CNT_W, 4, width of the shift-amount field and the step counter

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET_N  input  1  asynchronous, active-low reset
START  input  1  request pulse; sampled only when BUSY=0
DIR  input  1  0 = left, 1 = right
DATA1  input  8  value to shift
DATA2  input  8  [7:6] mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved; [3:0] amount; [5:4] ignored
RESULT  output  8  shifted value; held stable from DONE until the next accepted START
BUSY  output  1  high while in SHIFT
DONE  output  1  one-cycle pulse when RESULT is valid
ERROR  output  1  set with DONE for reserved mode; held until the next accepted START

Behaviour:
- Reset (RESET_N=0, any time, including mid-operation): state=IDLE, RESULT=8'h00, counter=0, BUSY=0, DONE=0, ERROR=0. Takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, SHIFT, FIN. BUSY=(state==SHIFT). DONE=(state==FIN).
- Accept: START=1 at a rising edge while state is IDLE or FIN. On that edge:
  - Latch DATA1 into the shift register, and latch mode and DIR.
  - Load the counter with the effective count N.
  - Clear ERROR.
  - Go to SHIFT if N>0, else go to FIN.
- START while in SHIFT is ignored; no queuing.
- Effective count N from amount A=DATA2[3:0]:
  - Logical or arithmetic: N = min(A, 8). Eight steps naturally yield zero fill or sign fill, so no special case is needed.
  - Rotate: N = A mod 8, so A=8 gives N=0.
  - Reserved mode 11: N=0 and ERROR=1 at the FIN entry. RESULT is DATA1 unchanged.
- Per-step operation, in SHIFT on each edge:
  - Left logical or arithmetic: reg = {reg[6:0], 1'b0}. Arithmetic-left equals logical-left.
  - Left rotate: reg = {reg[6:0], reg[7]}.
  - Right logical: reg = {1'b0, reg[7:1]}.
  - Right arithmetic: reg = {reg[7], reg[7:1]}.
  - Right rotate: reg = {reg[0], reg[7:1]}.
  - After the step, the counter decrements. The edge that performs the step with counter==1 moves the state to FIN.
- Latency: with the accept edge as E0, DONE is high in the cycle following edge E0+N. BUSY is high for exactly N cycles. N=0 gives DONE in the cycle right after E0.
- FIN lasts one cycle, then returns to IDLE unless START is accepted. Back-to-back START in FIN is legal and gives no idle gap.
- RESULT is the shift register, driven directly. It changes during SHIFT, but consumers read it only on DONE.
- DATA1, DATA2 and DIR changes after the accept edge have no effect on the operation in flight.

Test Plan:
1. Right logical: DATA1=8'hB4, DATA2=8'h03, DIR=1, START pulse → BUSY high 3 cycles, DONE pulse, RESULT=8'h16, ERROR=0.
2. Right arithmetic and saturation:
   - DATA1=8'hB4, DATA2=8'h42, DIR=1 → RESULT=8'hED after 2 cycles.
   - DATA1=8'h80, DATA2=8'h49 (A=9) → BUSY 8 cycles, RESULT=8'hFF.
3. Rotates and left shift:
   - DATA1=8'h81, DATA2=8'h81, DIR=0 → RESULT=8'h03.
   - Same with DIR=1 → RESULT=8'hC0.
   - DATA1=8'hFF, DATA2=8'h0C, DIR=0 → BUSY 8 cycles, RESULT=8'h00.
4. Zero-count cases:
   - DATA2=8'h00 with DATA1=8'h5A → no BUSY, DONE the next cycle, RESULT=8'h5A.
   - DATA2=8'h88 (rotate by 8) → same response.
   - DATA2=8'hC3 (reserved mode) → DONE with ERROR=1, RESULT=8'h5A. The next valid START clears ERROR.
5. Handshake:
   - Issue START again during BUSY with different data → ignored; the first result is unaffected.
   - Issue START in the FIN cycle → accepted; the second result is correct with no IDLE cycle between.
6. Reset: assert RESET_N=0 mid-SHIFT, between clock edges → RESULT=0, BUSY=0, DONE=0 and ERROR=0 immediately. After release, a new operation completes normally.
